// File: rtl/gray_pad_stream.sv
// RGB-to-luma front end that wraps the interior image in a one-pixel zero border
// and streams the padded frame in raster order, one byte per issue.
module gray_pad_stream #(
  parameter int IMG_W = 480,
  parameter int IMG_H = 360
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof,
  output logic       done,
  output logic       busy
);

  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eol_q, out_eol_d;
  logic          out_eof_q, out_eof_d;
  logic          done_q, done_d;

  logic          border;
  logic          issue;
  logic [19:0]   gray_sum;
  logic [7:0]    gray;

  assign border = (row_q == '0) || (row_q == ROW_LAST) ||
                  (col_q == '0) || (col_q == COL_LAST);
  assign in_ready = (state_q == ACTIVE) && !border;
  assign issue    = (state_q == ACTIVE) && (border || in_valid);

  assign gray_sum = 20'(in_r) * 20'd1224 + 20'(in_g) * 20'd2404 + 20'(in_b) * 20'd466;
  assign gray     = 8'(gray_sum >> 12);

  // The done cycle is the tail of the frame, so busy covers it too.
  assign busy = (state_q != IDLE) || done_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sof_d   = 1'b0;
    out_eol_d   = 1'b0;
    out_eof_d   = 1'b0;
    done_d      = (state_q == DONE);

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the old frame.
        if (start && !done_q) begin
          state_d = ACTIVE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ACTIVE: begin
        if (issue) begin
          out_valid_d = 1'b1;
          out_data_d  = border ? 8'd0 : gray;
          out_sof_d   = (row_q == '0) && (col_q == '0);
          out_eol_d   = (col_q == COL_LAST);
          out_eof_d   = (col_q == COL_LAST) && (row_q == ROW_LAST);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gray_pad_stream.sv
// Scoreboard bench for gray_pad_stream on a 4x3 image: the driver pushes the whole
// expected padded frame, a negedge monitor pops and compares every beat.
module tb_gray_pad_stream;
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int PW  = W + 2;
  localparam int PH  = H + 2;
  localparam int TOT = PW * PH;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_r = 8'd0, in_g = 8'd0, in_b = 8'd0;
  logic       in_ready, out_valid, out_sof, out_eol, out_eof, done, busy;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  gray_pad_stream #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
    .out_eol(out_eol), .out_eof(out_eof), .done(done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];      // {data, sof, eol, eof}
  logic exp_ov_pend = 1'b0;   // an issue is expected at the coming edge
  logic exp_ov = 1'b0;        // out_valid expected in the current cycle
  logic [7:0] last_data = 8'd0;
  logic eof_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int gray(input int r, input int g, input int b);
    return (r * 1224 + g * 2404 + b * 466) / 4096;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) exp_ov <= 1'b0;
    else      exp_ov <= exp_ov_pend;

  // Monitor
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst) begin
      chk("out_valid", out_valid, exp_ov);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {out_data, out_sof, out_eol, out_eof}, e);
          last_data = e[10:3];
        end
      end else begin
        chk("data_hold", out_data, last_data);
      end
      chk("done", done, eof_prev);
      eof_prev = out_valid && out_eof;
    end else begin
      last_data = 8'd0;
      eof_prev  = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 0);
      in_valid = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // mode 0: white, valid held; 1: directed colours; 2: 3-cycle stall at (1,2);
  // 3: random valid + start spam; 4: reset after 13 issued beats.
  task automatic run_frame(input int mode);
    int pr[W*H], pg[W*H], pb[W*H];
    int pos, idx, stall_left, guard, rr, cc, d;
    bit interior, v, iss;
    for (int i = 0; i < W * H; i++) begin
      pr[i] = (mode == 0) ? 255 : int'($urandom_range(0, 255));
      pg[i] = (mode == 0) ? 255 : int'($urandom_range(0, 255));
      pb[i] = (mode == 0) ? 255 : int'($urandom_range(0, 255));
    end
    if (mode == 1) begin
      pr[0] = 255; pg[0] = 0;   pb[0] = 0;
      pr[1] = 0;   pg[1] = 255; pb[1] = 0;
      pr[2] = 0;   pg[2] = 0;   pb[2] = 255;
      pr[3] = 0;   pg[3] = 0;   pb[3] = 0;
      pr[4] = 100; pg[4] = 150; pb[4] = 200;
    end
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++) begin
        d = (r == 0 || r == PH - 1 || c == 0 || c == PW - 1) ? 0 :
            gray(pr[(r-1)*W + c-1], pg[(r-1)*W + c-1], pb[(r-1)*W + c-1]);
        exp_q.push_back({8'(d), 1'(r == 0 && c == 0), 1'(c == PW - 1),
                         1'(c == PW - 1 && r == PH - 1)});
      end

    start = 1'b1;
    exp_ov_pend = 1'b0;
    chk("pre_start_busy", busy, 0);
    chk("pre_start_in_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    pos = 0; idx = 0; guard = 0;
    stall_left = (mode == 2) ? 3 : 0;

    while (pos < TOT && guard < 400) begin
      guard++;
      rr = pos / PW;
      cc = pos % PW;
      interior = (rr >= 1 && rr <= H && cc >= 1 && cc <= W);
      chk("in_ready", in_ready, 32'(interior));
      chk("busy", busy, 1);
      if (mode == 4 && pos == 13) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_outputs", {in_ready, out_valid, out_data, out_sof, out_eol, out_eof, done, busy}, 0);
        exp_q.delete();
        exp_ov_pend = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        return;
      end
      start = (mode == 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
      v = (mode == 3) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (interior && idx == 1 && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end
      in_valid = v;
      if (interior && v) begin
        in_r = 8'(pr[idx]); in_g = 8'(pg[idx]); in_b = 8'(pb[idx]);
      end else begin
        in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
      end
      iss = !interior || v;
      exp_ov_pend = iss;
      if (iss) pos++;
      if (interior && v) idx++;
      @(negedge clk);
    end
    if (pos < TOT) begin
      errors++;
      $display("FAIL frame_timeout actual=%0d required=%0d", pos, TOT);
    end

    // eof cycle, then done cycle
    exp_ov_pend = 1'b0;
    in_valid = 1'b1;
    start = (mode == 3);
    chk("eof_busy", busy, 1);
    chk("eof_in_ready", in_ready, 0);
    @(negedge clk);
    start = (mode == 3);
    chk("done_busy", busy, 1);
    chk("done_in_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    chk("post_done_busy", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {in_ready, out_valid, out_data, out_sof, out_eol, out_eof, done, busy}, 0);
    rst = 1'b1;
    idle(2);
    run_frame(0);
    idle(2);
    run_frame(1);
    idle(1);
    run_frame(2);
    idle(1);
    run_frame(3);
    run_frame(3);
    idle(2);
    run_frame(4);
    idle(3);
    run_frame(0);
    for (int i = 0; i < 4; i++) begin
      run_frame(3);
      idle(1);
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_pad_stream.md
# gray_pad_stream

Front-end stage ahead of the `sobel` edge filter. It accepts an RGB pixel stream in raster order and converts each pixel to 8-bit luma. It wraps the image in a one-pixel zero border and emits the resulting (IMG_W+2)×(IMG_H+2) grayscale stream, one byte per accepted cycle, on the `sobel` `data` input. This moves the padding and grayscale work now done in the bench into synthesizable RTL.

## Interface
- IMG_W, 480, interior image width in pixels
- IMG_H, 360, interior image height in pixels
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a frame when in IDLE, ignored otherwise
- in_valid  in  1  in_r/in_g/in_b hold a valid interior pixel
- in_ready  out  1  block consumes the input pixel this cycle if in_valid is high
- in_r, in_g, in_b  in  8 each  input colour components
- out_valid  out  1  out_data is a valid padded-frame pixel
- out_data  out  8  grayscale pixel; 0 on the border
- out_sof  out  1  with out_valid; first pixel of the frame (row 0, col 0)
- out_eol  out  1  with out_valid; last pixel of a row (col IMG_W+1)
- out_eof  out  1  with out_valid; last pixel of the frame
- done  out  1  one-cycle pulse after the out_eof beat
- busy  out  1  high in ACTIVE and DONE

## Operation
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE→ACTIVE on start; row and col clear to 0.
  - ACTIVE→DONE after the pixel at (IMG_H+1, IMG_W+1) is issued.
  - DONE→IDLE unconditionally after 1 cycle.
- Counters: col 0..IMG_W+1, row 0..IMG_H+1. On each issue, col increments. At IMG_W+1, col wraps to 0 and row increments.
- Border position: row==0, row==IMG_H+1, col==0 or col==IMG_W+1.
  - In ACTIVE, a border position is always issued with data 0, without consuming input.
  - in_ready is low at border positions.
- Interior position in ACTIVE: in_ready=1.
  - If in_valid is high, the pixel is consumed and issued with gray data.
  - If in_valid is low, nothing is issued and the counters hold (stall).
- in_ready is 0 in IDLE and DONE. Input is never consumed outside the interior positions.
- Gray conversion: Y = (R*1224 + G*2404 + B*466) >> 12, computed in 20-bit unsigned arithmetic.
  - Maximum sum is 255*4094 = 1043970, so no overflow occurs.
  - The result is at most 254, so no saturation is needed.
  - out_data takes Y[19:12]'s low 8 bits.
- A frame emits exactly (IMG_W+2)(IMG_H+2) out_valid beats and consumes exactly IMG_W*IMG_H inputs.
- start while busy has no effect on state, counters or outputs.

## Timing
- Reset (rst low, asynchronous): state IDLE, row=col=0, and every output low: in_ready, out_valid, out_data=0, out_sof, out_eol, out_eof, done, busy.
  - Assertion mid-frame aborts the frame immediately; no partial-frame beats follow.
- in_ready is combinational from state, row and col. It never depends on in_valid.
- All out_* signals are registered. An issue in cycle n gives out_valid=1 with its data and flags in cycle n+1. If nothing issued in cycle n, out_valid=0 in cycle n+1 and out_data holds its last value.
- Cycle sequence with start sampled high at edge k:
  - busy high after edge k.
  - First issue at edge k+1, so out_sof is visible after edge k+1.
  - With no stalls, beats are back-to-back for (IMG_W+2)(IMG_H+2) cycles.
- done is high for exactly the cycle after the out_eof beat. busy drops the cycle after done.
- A start in the same cycle done is high is ignored. A new frame may start from IDLE the cycle after done.

## Test plan
- IMG_W=4, IMG_H=3, start, all inputs (255,255,255) with in_valid held high -> exactly 30 out_valid beats, back-to-back. The 12 interior beats are 254 and the 18 border beats are 0. out_sof is on beat 0, out_eol on beats 5, 11, 17, 23, 29, and out_eof on beat 29. done pulses 1 cycle later.
- Single-colour inputs at an interior pixel:
  - (255,0,0) -> 76
  - (0,255,0) -> 149
  - (0,0,255) -> 29
  - (0,0,0) -> 0
  - (100,150,200) -> 140
- Drop in_valid for 3 cycles at interior (1,2) -> in_ready stays high and out_valid is low for 3 cycles. The counters hold, the next accepted pixel appears at (1,2), and the beat total is still 30.
- Assert start repeatedly mid-frame and on the done cycle -> no restart and no extra beats. A start 1 cycle after done begins a new frame with out_sof.
- Pull rst low at beat 13 -> all outputs go to 0 immediately and in_ready drops. After release, outputs stay idle until start, and the next frame is complete and correct.
- Check in_ready over one frame -> it is high only at the 12 interior positions and never at a border or outside ACTIVE.
